// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of async_fifo. A requester keeps the
// grant for a whole packet, up to MAXBURST beats, so packets are never interleaved.

module fifo_wr_arbiter_lane #(
  parameter int IDW  = 2,
  parameter int LANE = 0
) (
  input  logic [IDW-1:0] sel,
  input  logic           req,
  input  logic           ok,
  output logic           ack
);
  assign ack = (sel == IDW'(LANE)) & req & ok;
endmodule

module fifo_wr_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic                  busy,
  output logic [IDW-1:0]        owner
);

  localparam int BW = $clog2(MAXBURST + 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d, beat_inc;
  logic [IDW-1:0]  sel, cidx;
  logic            found;
  logic            grant_ok;
  logic [NREQ-1:0] ack_w;
  int              cand;

  // Wraps at NREQ-1 rather than at 2**IDW so non-power-of-2 NREQ stays valid.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] x);
    return (x == IDW'(NREQ - 1)) ? '0 : x + 1'b1;
  endfunction

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Selection: locked owner, else first requester at or after rr_ptr.
  always_comb begin
    sel   = rr_ptr_q;
    found = 1'b0;
    cand  = 0;
    cidx  = '0;
    if (state_q == LOCK) begin
      sel = lock_id_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = int'(rr_ptr_q) + k;
        if (cand >= NREQ) cand = cand - NREQ;
        cidx = IDW'(cand);
        if (!found && req[cidx]) begin
          found = 1'b1;
          sel   = cidx;
        end
      end
    end
  end

  assign grant_ok = ~wfull & wrst_n;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.IDW(IDW), .LANE(i)) u_lane (
      .sel (sel),
      .req (req[i]),
      .ok  (grant_ok),
      .ack (ack_w[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    beat_inc   = beat_cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (|ack_w) begin
          if (req_last[sel] || MAXBURST == 1) begin
            rr_ptr_d = wrap_inc(sel);
          end else begin
            state_d    = LOCK;
            lock_id_d  = sel;
            beat_cnt_d = BW'(1);
          end
        end
      end
      LOCK: begin
        if (|ack_w) begin
          if (req_last[lock_id_q] || beat_inc == BW'(MAXBURST)) begin
            state_d    = IDLE;
            rr_ptr_d   = wrap_inc(lock_id_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack   = ack_w;
    winc  = |ack_w;
    wdata = req_data[sel*DSIZE +: DSIZE];
    owner = sel;
    busy  = (state_q == LOCK);
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed packet scenarios then random traffic,
// each cycle compared against a packet-level round-robin reference model.

module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DSIZE = 8;
  localparam int MAXBURST = 4;

  logic        wclk = 1'b0;
  logic        wrst_n = 1'b0;
  logic [3:0]  req = '0, req_last = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        winc, wfull = 1'b0, busy;
  logic [7:0]  wdata;
  logic [1:0]  owner;

  int passed = 0, total = 0;

  // reference model: current packet holder (-1 none), beats written by it, rr pointer
  int m_lock = -1, m_beats = 0, m_rr = 0;

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_last(req_last),
    .req_data(req_data), .ack(ack), .winc(winc), .wdata(wdata),
    .wfull(wfull), .busy(busy), .owner(owner)
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_lock = -1; m_beats = 0; m_rr = 0;
  endtask

  // Called at posedge+1; inputs applied, checked at the falling edge, returns at next posedge+1.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic f, input int xack);
    int s, idx;
    logic fnd;
    logic [3:0] a;
    logic eb;
    req = r; req_last = l; wfull = f; req_data = $urandom;
    #4;
    eb = (m_lock >= 0);
    if (m_lock >= 0) s = m_lock;
    else begin
      s = m_rr; fnd = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (!fnd && r[idx]) begin s = idx; fnd = 1'b1; end
      end
    end
    a = '0;
    if (!f && r[s]) a[s] = 1'b1;
    chk("ack", ack, a);
    chk("winc", winc, |a);
    chk("owner", owner, s);
    chk("busy", busy, eb);
    chk("winc_while_full", winc & wfull, 0);
    if (|a) chk("wdata", wdata, (req_data >> (8 * s)) & 32'hff);
    if (xack >= 0) chk("directed_ack", ack, xack);
    if (|a) begin
      m_beats++;
      if (l[s] || m_beats == MAXBURST) begin
        m_lock = -1; m_beats = 0; m_rr = (s + 1) % NREQ;
      end else m_lock = s;
    end
    @(posedge wclk); #1;
  endtask

  task automatic do_reset();
    wrst_n = 1'b0; req = 4'b1111; req_last = '0; wfull = 1'b0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_winc", winc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    model_reset();
    @(posedge wclk); #1;
    wrst_n = 1'b1;
  endtask

  initial begin
    int o5[6];
    @(posedge wclk); #1;
    do_reset();

    // 1: everyone single-beat, round robin
    for (int k = 0; k < 5; k++) step(4'b1111, 4'b1111, 1'b0, 1 << (k % 4));

    // 2: 3-beat packet from req0, req1 waiting
    do_reset();
    step(4'b0011, 4'b0010, 1'b0, 4'b0001);
    chk("t2_busy_after_b1", busy, 1);
    step(4'b0011, 4'b0010, 1'b0, 4'b0001);
    step(4'b0011, 4'b0011, 1'b0, 4'b0001);
    chk("t2_busy_after_b3", busy, 0);
    step(4'b0010, 4'b0010, 1'b0, 4'b0010);

    // 3: burst cap without last
    do_reset();
    for (int k = 0; k < 4; k++) step(4'b0011, 4'b0010, 1'b0, 4'b0001);
    step(4'b0011, 4'b0010, 1'b0, 4'b0010);
    step(4'b0001, 4'b0000, 1'b0, 4'b0001);

    // 4: FIFO full in the middle of a locked packet
    do_reset();
    step(4'b0001, 4'b0000, 1'b0, 4'b0001);
    step(4'b0001, 4'b0000, 1'b0, 4'b0001);
    for (int k = 0; k < 5; k++) step(4'b0101, 4'b0100, 1'b1, 4'b0000);
    step(4'b0101, 4'b0101, 1'b0, 4'b0001);
    step(4'b0100, 4'b0100, 1'b0, 4'b0100);

    // 5: owner pauses while another requester waits
    do_reset();
    step(4'b0001, 4'b0000, 1'b0, 4'b0001);
    for (int k = 0; k < 3; k++) step(4'b0100, 4'b0100, 1'b0, 4'b0000);
    step(4'b0101, 4'b0100, 1'b0, 4'b0001);
    step(4'b0101, 4'b0101, 1'b0, 4'b0001);
    step(4'b0100, 4'b0100, 1'b0, 4'b0100);

    // 6: reset in the middle of a lock
    do_reset();
    step(4'b0011, 4'b0000, 1'b0, 4'b0001);
    req = 4'b0011; req_last = '0;
    #2;
    chk("t6_locked", busy, 1);
    wrst_n = 1'b0;
    #1;
    chk("t6_rst_winc", winc, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ack", ack, 0);
    model_reset();
    @(posedge wclk); #1;
    wrst_n = 1'b1;
    step(4'b1010, 4'b1010, 1'b0, 4'b0010);

    // random traffic
    for (int k = 0; k < 400; k++)
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 3), -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
